// File: rtl/mem_io_bridge.sv
// mem_io_bridge
//   Decodes the CPU memory port into block RAM accesses (addresses below
//   IO_BASE) and a small memory-mapped I/O block. The I/O block has an LED
//   register, synchronised switches, a TX byte FIFO and a status register.
//   Every target is read with the same 1-cycle latency: the address is
//   presented in cycle N and mem_out carries the data in cycle N+1.
//
// Ports
//   clk        system clock, rising edge
//   reset      synchronous, active-high reset
//   mem_addr   CPU address
//   writedata  CPU write data
//   MEM_WR_S   CPU write enable
//   mem_out    read data returned to the CPU (cycle after the address)
//   ram_addr   block RAM address (mem_addr passed through)
//   ram_din    block RAM write data (writedata passed through)
//   ram_we     block RAM write enable, RAM space only
//   ram_dout   block RAM registered read data
//   switches   raw asynchronous switch inputs
//   leds       LED register
//   tx_data    TX FIFO head byte
//   tx_valid   TX FIFO non-empty
//   tx_ready   consumer takes the head byte this cycle
//
// I/O map (offset from IO_BASE)
//   0x00 LED     R/W
//   0x01 SW      R
//   0x02 TXDATA  W (push one byte)
//   0x03 STATUS  R {overflow, full, empty, count}; any write clears overflow

module mem_io_bridge #(
  parameter int                 WIDTH   = 16,
  parameter logic [WIDTH-1:0]   IO_BASE = 16'hFF00,
  parameter int                 FIFO_AW = 3,
  parameter int                 LED_W   = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] mem_addr,
  input  logic [WIDTH-1:0] writedata,
  input  logic             MEM_WR_S,
  output logic [WIDTH-1:0] mem_out,
  output logic [WIDTH-1:0] ram_addr,
  output logic [WIDTH-1:0] ram_din,
  output logic             ram_we,
  input  logic [WIDTH-1:0] ram_dout,
  input  logic [LED_W-1:0] switches,
  output logic [LED_W-1:0] leds,
  output logic [7:0]       tx_data,
  output logic             tx_valid,
  input  logic             tx_ready
);

  localparam int               DEPTH   = 1 << FIFO_AW;
  localparam logic [FIFO_AW:0] CNT_MAX = {1'b1, {FIFO_AW{1'b0}}};
  localparam logic [WIDTH-1:0] OFF_LED = WIDTH'(0);
  localparam logic [WIDTH-1:0] OFF_SW  = WIDTH'(1);
  localparam logic [WIDTH-1:0] OFF_TX  = WIDTH'(2);
  localparam logic [WIDTH-1:0] OFF_ST  = WIDTH'(3);

  logic [7:0]         fifo_mem [DEPTH];
  logic [FIFO_AW-1:0] wr_ptr, rd_ptr;
  logic [FIFO_AW:0]   count;
  logic               overflow;
  logic [LED_W-1:0]   sw_meta, sw_sync;
  logic               sel_io;
  logic [WIDTH-1:0]   io_rd_q;
  logic [WIDTH-1:0]   io_rd_next;

  logic             is_io;
  logic [WIDTH-1:0] offset;
  logic             io_wr;
  logic             full, empty;
  logic             push, pop, accept;

  assign is_io    = (mem_addr >= IO_BASE);
  assign offset   = mem_addr - IO_BASE;
  assign io_wr    = MEM_WR_S & is_io;

  assign ram_addr = mem_addr;
  assign ram_din  = writedata;
  assign ram_we   = MEM_WR_S & ~is_io;

  assign full     = (count == CNT_MAX);
  assign empty    = (count == '0);
  assign tx_valid = ~empty;
  assign tx_data  = fifo_mem[rd_ptr];

  // A full FIFO can still take a byte when the head leaves in the same cycle.
  assign pop      = tx_valid & tx_ready;
  assign push     = io_wr & (offset == OFF_TX);
  assign accept   = push & (~full | pop);

  assign mem_out  = sel_io ? io_rd_q : ram_dout;

  // Value an I/O read would return right now; captured at the clock edge so
  // the CPU sees it one cycle later, matching the RAM latency.
  always_comb begin
    io_rd_next = '0;
    if (offset == OFF_LED) begin
      io_rd_next = {{(WIDTH-LED_W){1'b0}}, leds};
    end else if (offset == OFF_SW) begin
      io_rd_next = {{(WIDTH-LED_W){1'b0}}, sw_sync};
    end else if (offset == OFF_ST) begin
      io_rd_next = {{(WIDTH-FIFO_AW-4){1'b0}}, overflow, full, empty, count};
    end
  end

  // Read-select register, I/O read register, LEDs and switch synchroniser.
  always_ff @(posedge clk) begin
    if (reset) begin
      sel_io  <= 1'b0;
      io_rd_q <= '0;
      leds    <= '0;
      sw_meta <= '0;
      sw_sync <= '0;
    end else begin
      sel_io  <= is_io;
      io_rd_q <= is_io ? io_rd_next : '0;
      sw_meta <= switches;
      sw_sync <= sw_meta;
      if (io_wr && offset == OFF_LED) begin
        leds <= writedata[LED_W-1:0];
      end
    end
  end

  // FIFO pointers, occupancy and sticky overflow flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (accept) begin
        wr_ptr <= wr_ptr + FIFO_AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + FIFO_AW'(1);
      end
      if (accept && !pop) begin
        count <= count + (FIFO_AW+1)'(1);
      end else if (pop && !accept) begin
        count <= count - (FIFO_AW+1)'(1);
      end
      if (io_wr && offset == OFF_ST) begin
        overflow <= 1'b0;
      end else if (push && !accept) begin
        overflow <= 1'b1;
      end
    end
  end

  // FIFO storage needs no reset; stale bytes are hidden by count.
  always_ff @(posedge clk) begin
    if (accept) begin
      fifo_mem[wr_ptr] <= writedata[7:0];
    end
  end

endmodule

// File: tb/tb_mem_io_bridge.sv
// tb_mem_io_bridge
//   Drives mem_io_bridge with directed and random CPU traffic and compares
//   its outputs against a transaction-level model: an array for RAM, a queue
//   for the TX FIFO, and a short switch history for the synchroniser delay.

module tb_mem_io_bridge;

  localparam logic [15:0] IO = 16'hFF00;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] mem_addr = '0;
  logic [15:0] writedata = '0;
  logic        MEM_WR_S = 1'b0;
  logic [15:0] mem_out;
  logic [15:0] ram_addr;
  logic [15:0] ram_din;
  logic        ram_we;
  logic [15:0] ram_dout;
  logic [9:0]  switches = '0;
  logic [9:0]  leds;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready = 1'b0;

  int checks = 0;
  int errors = 0;

  // Block RAM stand-in: read-before-write, 1-cycle registered output.
  logic [15:0] ram [256];

  // Reference model state.
  logic [15:0] exp_ram [256];
  logic [9:0]  m_leds;
  logic        m_ovf;
  logic [7:0]  m_q [$];
  logic [9:0]  sw_hist [$];

  mem_io_bridge dut (
    .clk(clk), .reset(reset), .mem_addr(mem_addr), .writedata(writedata),
    .MEM_WR_S(MEM_WR_S), .mem_out(mem_out), .ram_addr(ram_addr),
    .ram_din(ram_din), .ram_we(ram_we), .ram_dout(ram_dout),
    .switches(switches), .leds(leds), .tx_data(tx_data),
    .tx_valid(tx_valid), .tx_ready(tx_ready)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (ram_we) ram[ram_addr[7:0]] <= ram_din;
    ram_dout <= ram[ram_addr[7:0]];
  end

  task automatic check_output(input string tag, input logic [15:0] got,
                              input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s got=%h expected=%h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] status_word();
    int n;
    n = m_q.size();
    return {9'b0, m_ovf, (n == 8), (n == 0), 4'(n)};
  endfunction

  function automatic logic [15:0] io_read(input logic [15:0] off);
    case (off)
      16'd0:   return {6'b0, m_leds};
      16'd1:   return {6'b0, sw_hist[$-1]};
      16'd3:   return status_word();
      default: return 16'h0000;
    endcase
  endfunction

  // One CPU cycle: drive inputs, check combinational/registered outputs,
  // predict the next read and advance the model, then check mem_out.
  task automatic apply_stimulus(input logic we, input logic [15:0] addr,
                                input logic [15:0] data, input logic rdy);
    logic [15:0] exp;
    logic        io;
    logic        pop;
    logic [15:0] off;
    int          n;
    mem_addr  = addr;
    writedata = data;
    MEM_WR_S  = we;
    tx_ready  = rdy;
    #1;
    io  = (addr >= IO);
    off = addr - IO;
    n   = m_q.size();
    if (!reset) begin
      check_output("ram_we", {15'b0, ram_we}, {15'b0, we && !io});
      check_output("tx_valid", {15'b0, tx_valid}, {15'b0, n != 0});
      if (n != 0) check_output("tx_data", {8'b0, tx_data}, {8'b0, m_q[0]});
      check_output("leds", {6'b0, leds}, {6'b0, m_leds});
    end
    if (reset || !io) exp = exp_ram[addr[7:0]];
    else              exp = io_read(off);
    if (reset) begin
      m_q.delete();
      m_leds  = '0;
      m_ovf   = 1'b0;
      sw_hist = '{10'd0, 10'd0};
    end else begin
      pop = (n != 0) && rdy;
      if (we && !io) exp_ram[addr[7:0]] = data;
      if (pop) void'(m_q.pop_front());
      if (we && io) begin
        case (off)
          16'd0: m_leds = data[9:0];
          16'd2: if (n < 8 || pop) m_q.push_back(data[7:0]); else m_ovf = 1'b1;
          16'd3: m_ovf = 1'b0;
          default: ;
        endcase
      end
      sw_hist.push_back(switches);
      if (sw_hist.size() > 4) void'(sw_hist.pop_front());
    end
    @(posedge clk);
    #1;
    check_output("mem_out", mem_out, exp);
  endtask

  task automatic do_reset(input int cycles);
    reset = 1'b1;
    for (int i = 0; i < cycles; i++) apply_stimulus(1'b0, 16'h0000, 16'h0000, 1'b0);
    reset = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) begin
      ram[i]     = '0;
      exp_ram[i] = '0;
    end
    m_leds  = '0;
    m_ovf   = 1'b0;
    sw_hist = '{10'd0, 10'd0};

    // Reset state.
    do_reset(2);
    apply_stimulus(1'b0, IO + 16'd3, 16'h0, 1'b0);
    check_output("reset_status", mem_out, 16'h0010);

    // RAM write then read back.
    apply_stimulus(1'b1, 16'h0010, 16'h1234, 1'b0);
    apply_stimulus(1'b0, 16'h0010, 16'h0000, 1'b0);
    check_output("ram_read", mem_out, 16'h1234);

    // LED register.
    apply_stimulus(1'b1, IO, 16'h03FF, 1'b0);
    apply_stimulus(1'b0, IO, 16'h0000, 1'b0);
    check_output("led_read", mem_out, 16'h03FF);

    // Switch synchroniser delay.
    switches = 10'h2A5;
    apply_stimulus(1'b0, IO + 16'd1, 16'h0, 1'b0);
    check_output("sw_early", mem_out, 16'h0000);
    for (int i = 0; i < 3; i++) apply_stimulus(1'b0, IO + 16'd1, 16'h0, 1'b0);
    check_output("sw_read", mem_out, 16'h02A5);

    // Overflow: nine pushes into a depth-8 FIFO.
    for (int i = 0; i < 9; i++) apply_stimulus(1'b1, IO + 16'd2, 16'(8'h11 + i), 1'b0);
    apply_stimulus(1'b0, IO + 16'd3, 16'h0, 1'b0);
    check_output("status_ovf_full", mem_out, 16'h0068);
    apply_stimulus(1'b1, IO + 16'd3, 16'h0, 1'b0);
    apply_stimulus(1'b0, IO + 16'd3, 16'h0, 1'b0);
    check_output("status_cleared", mem_out, 16'h0028);
    for (int i = 0; i < 8; i++) begin
      check_output("drain_order", {8'b0, tx_data}, 16'(8'h11 + i));
      apply_stimulus(1'b0, 16'h0000, 16'h0, 1'b1);
    end
    apply_stimulus(1'b0, IO + 16'd3, 16'h0, 1'b1);
    check_output("status_empty", mem_out, 16'h0010);

    // Push into a full FIFO while the head is popped.
    for (int i = 0; i < 8; i++) apply_stimulus(1'b1, IO + 16'd2, 16'(8'h40 + i), 1'b0);
    apply_stimulus(1'b1, IO + 16'd2, 16'h00AA, 1'b1);
    apply_stimulus(1'b0, IO + 16'd3, 16'h0, 1'b0);
    check_output("full_push_pop", mem_out, 16'h0028);

    // Reset with bytes queued and LEDs lit.
    do_reset(1);
    for (int i = 0; i < 5; i++) apply_stimulus(1'b1, IO + 16'd2, 16'(i), 1'b0);
    apply_stimulus(1'b1, IO, 16'h0155, 1'b0);
    do_reset(1);
    check_output("rst_tx_valid", {15'b0, tx_valid}, 16'h0000);
    check_output("rst_leds", {6'b0, leds}, 16'h0000);
    apply_stimulus(1'b0, IO + 16'd3, 16'h0, 1'b0);
    check_output("rst_status", mem_out, 16'h0010);

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      logic [15:0] a;
      int sel;
      sel = $urandom_range(0, 9);
      if (sel < 4)       a = 16'($urandom_range(0, 255));
      else if (sel < 9)  a = IO + 16'($urandom_range(0, 5));
      else               a = 16'($urandom_range(16'hFF06, 16'hFFFF));
      if ($urandom_range(0, 7) == 0) switches = 10'($urandom);
      apply_stimulus(1'($urandom), a, 16'($urandom), $urandom_range(0, 3) == 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
